start_seq_counter: RTL

- Parametrised start-triggered state sequencer; the registered successor of the fixed 3-bit next-state decoder.
- Holds its own state register and steps through 0..LAST up or down, one value per clock.
- Supports one-shot or auto-repeat, pause, abort, a terminal flag and a done pulse.
- Sits beside datapath blocks as the step/phase generator for a controlled operation.

---
 rtl/start_seq_counter.sv | 67 ++++++
 1 files changed

// File: rtl/start_seq_counter.sv
// start_seq_counter: start-triggered up/down state sequencer with repeat, pause, abort, terminal flag and done pulse
// Ports: clk, rst (sync, active-high); start, dir, mode_repeat, pause, abort (controls);
//        q (registered state value), busy (registered, high in RUN), done (registered one-cycle pulse),
//        at_term (RUN and q at terminal value: LAST going up, 1 going down).
module start_seq_counter #(
  parameter int WIDTH = 3,
  parameter int LAST  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             mode_repeat,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             at_term
);
  if (WIDTH < 2 || WIDTH > 16 || LAST < 1 || LAST > (1 << WIDTH) - 1) begin : g_bad_param
    $error("start_seq_counter: illegal WIDTH/LAST");
  end
  localparam logic [WIDTH-1:0] LAST_Q = WIDTH'(LAST);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic   dir_r;
  logic [WIDTH-1:0] first;
  assign first   = dir_r ? LAST_Q : ONE;
  assign at_term = (state == RUN) && (q == (dir_r ? ONE : LAST_Q));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dir_r <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          dir_r <= dir;
          q     <= dir ? LAST_Q : ONE;
          busy  <= 1'b1;
        end
      end else if (abort) begin
        state <= IDLE;
        q     <= '0;
        busy  <= 1'b0;
      end else if (!pause) begin
        if (at_term) begin
          q    <= '0;
          done <= 1'b1;
          if (!mode_repeat) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else begin
          // q==0 in RUN is the wrap cycle of a repeating sequence: reload the first value
          q <= (q == '0) ? first : (dir_r ? q - ONE : q + ONE);
        end
      end
    end
  end
endmodule
